// File: rtl/piano_key_ctrl.sv
// Piano keyboard front end: per-key sync + debounce, lowest-key note select,
// and registered fundamental/harmonic rate words with gate and timed sustain.
//
// state   | meaning
// IDLE    | no note sounding, gate low, rates zero
// PLAY    | at least one debounced key held, note latched
// SUSTAIN | all keys released, note held until sustain timer expires
module piano_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 184320,
    parameter int SUSTAIN_CYCLES  = 9216000
) (
    input  logic        iCLK_18_4,
    input  logic        iRST,
    input  logic [7:0]  iKEY,
    input  logic [1:0]  iOctave,
    output logic [15:0] oVar_Rate,
    output logic [15:0] oArm_Rate,
    output logic        oGate,
    output logic [2:0]  oNote
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        SUSTAIN
    } state_t;

    localparam logic [17:0] DEB_LAST = 18'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] SUS_LAST = 24'(SUSTAIN_CYCLES - 1);

    logic [7:0]  sync_1;
    logic [7:0]  sync_2;
    logic [7:0]  kst;
    logic [17:0] deb_cnt [8];

    state_t      state;
    state_t      state_nxt;
    logic [23:0] sus_cnt;
    logic [23:0] sus_nxt;
    logic [15:0] var_nxt;
    logic [2:0]  note_nxt;
    logic [2:0]  low_idx;
    logic        latch;

    function automatic logic [15:0] rate_of(input logic [2:0] n, input logic [1:0] oct);
        logic [15:0] base;
        case (n)
            3'd0:    base = 16'd131;
            3'd1:    base = 16'd147;
            3'd2:    base = 16'd165;
            3'd3:    base = 16'd175;
            3'd4:    base = 16'd196;
            3'd5:    base = 16'd220;
            3'd6:    base = 16'd247;
            default: base = 16'd262;
        endcase
        return base << oct;
    endfunction

    // A key toggles its stable level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            sync_1 <= '0;
            sync_2 <= '0;
            kst    <= '0;
            for (int i = 0; i < 8; i++) deb_cnt[i] <= '0;
        end else begin
            sync_1 <= iKEY;
            sync_2 <= sync_1;
            for (int i = 0; i < 8; i++) begin
                if (sync_2[i] == kst[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    kst[i]     <= ~kst[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 18'd1;
                end
            end
        end
    end

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (kst[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        sus_nxt   = sus_cnt;
        var_nxt   = oVar_Rate;
        note_nxt  = oNote;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (kst != 8'd0) begin
                    state_nxt = PLAY;
                    latch     = 1'b1;
                end
            end
            PLAY: begin
                if (kst == 8'd0) begin
                    state_nxt = SUSTAIN;
                    sus_nxt   = '0;
                end else if (low_idx != oNote) begin
                    latch = 1'b1;
                end
            end
            SUSTAIN: begin
                // A new press takes priority over sustain expiry.
                if (kst != 8'd0) begin
                    state_nxt = PLAY;
                    latch     = 1'b1;
                end else if (sus_cnt == SUS_LAST) begin
                    state_nxt = IDLE;
                    var_nxt   = '0;
                end else begin
                    sus_nxt = sus_cnt + 24'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (latch) begin
            note_nxt = low_idx;
            var_nxt  = rate_of(low_idx, iOctave);
        end
    end

    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state     <= IDLE;
            sus_cnt   <= '0;
            oVar_Rate <= '0;
            oArm_Rate <= '0;
            oGate     <= 1'b0;
            oNote     <= '0;
        end else begin
            state     <= state_nxt;
            sus_cnt   <= sus_nxt;
            oVar_Rate <= var_nxt;
            oArm_Rate <= {var_nxt[14:0], 1'b0};
            oGate     <= (state_nxt != IDLE);
            oNote     <= note_nxt;
        end
    end

endmodule
